// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore-style control FSM for a multi-cycle RISC-V datapath with a shared
//   memory and a shared ALU. It supports lw, sw, R/I-type add/sub/slt/or/and,
//   beq and jal. Memory steps stall on a ready handshake. Illegal
//   instructions either park the FSM or are skipped. Retired instructions
//   are counted.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   op_code/funct3/funct7 : instruction fields from the instruction register
//   zero                : ALU zero flag, used by beq
//   mem_ready           : memory access completes this cycle
//   pc_write, ir_write, adr_src, mem_write, reg_write, imm_src,
//   alu_src_a, alu_src_b, alu_control, result_src : datapath controls
//   illegal             : high while parked on an illegal instruction
//   instret             : retired-instruction counter (wraps)
module multicycle_control_unit #(
  parameter int USE_MEM_READY   = 1,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op_code,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       imm_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_rdy;
  logic             retire;

  // With the handshake disabled every memory step completes in one cycle.
  assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  // Opcode plus funct3 combinations this controller can execute.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LW, OP_SW: ok = (f3 == 3'b010);
      OP_R, OP_I:   ok = (f3 == 3'b000) || (f3 == 3'b010) ||
                         (f3 == 3'b110) || (f3 == 3'b111);
      OP_BEQ:       ok = (f3 == 3'b000);
      OP_JAL:       ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = sub_en ? ALU_SUB : ALU_ADD;
      3'b010:  ctl = ALU_SLT;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    imm_src     = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    result_src  = 2'b00;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        result_src  = 2'b10;
        ir_write    = mem_rdy;
        pc_write    = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Computes the branch/jump target from OldPC while the register
        // file is being read.
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        imm_src     = (op_code == OP_JAL) ? 2'b11 : 2'b10;
        if (!is_legal(op_code, funct3)) begin
          state_d = (HALT_ON_ILLEGAL != 0) ? S_ERROR : S_FETCH;
        end else begin
          case (op_code)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_BEQ:       state_d = S_BEQ;
            default:      state_d = S_JAL;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        // op_code[5] separates sw (store) from lw (load).
        imm_src     = op_code[5] ? 2'b01 : 2'b00;
        state_d     = op_code[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_decode(funct3, op_code[5] & funct7);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        // Immediate forms have no subtract; funct7 is part of the immediate.
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_decode(funct3, 1'b0);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // ALU produces PC+4 (OldPC + 4) for the link register while the
        // PC loads the target computed during decode.
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        pc_write    = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ERROR: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset overrides everything so an aborted instruction cannot write.
    if (rst) begin
      retire      = 1'b0;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      imm_src     = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      result_src  = 2'b00;
      illegal     = 1'b0;
    end

    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. Two instances share all
// inputs: one halts on illegal instructions, the other skips them.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  op_code = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        funct7 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;

  logic        pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0]  imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;

  logic        n_pc_write, n_ir_write, n_adr_src, n_mem_write, n_reg_write, n_illegal;
  logic [1:0]  n_imm_src, n_alu_src_a, n_alu_src_b, n_result_src;
  logic [2:0]  n_alu_control;
  logic [31:0] n_instret;

  multicycle_control_unit #(.USE_MEM_READY(1), .HALT_ON_ILLEGAL(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .result_src(result_src), .illegal(illegal),
    .instret(instret));

  multicycle_control_unit #(.USE_MEM_READY(1), .HALT_ON_ILLEGAL(0), .CNT_W(32)) dut_nh (
    .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(n_pc_write), .ir_write(n_ir_write),
    .adr_src(n_adr_src), .mem_write(n_mem_write), .reg_write(n_reg_write),
    .imm_src(n_imm_src), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .alu_control(n_alu_control), .result_src(n_result_src), .illegal(n_illegal),
    .instret(n_instret));

  always #5 clk = ~clk;

  logic [16:0] act_main, act_nh;
  assign act_main = {pc_write, ir_write, adr_src, mem_write, reg_write, imm_src,
                     alu_src_a, alu_src_b, alu_control, result_src, illegal};
  assign act_nh   = {n_pc_write, n_ir_write, n_adr_src, n_mem_write, n_reg_write,
                     n_imm_src, n_alu_src_a, n_alu_src_b, n_alu_control,
                     n_result_src, n_illegal};

  typedef struct packed {
    logic [16:0] e;
    logic [31:0] cnt;
    logic        nh;
    logic [16:0] enh;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;
  logic [31:0] cnt = 0;
  bit   stim_done = 1'b0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // {pc_write, ir_write, adr_src, mem_write, reg_write, imm_src,
  //  alu_src_a, alu_src_b, alu_control, result_src, illegal}
  function automatic logic [16:0] v(input logic pcw, input logic irw, input logic adr,
                                    input logic mw, input logic rw, input logic [1:0] imm,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] alu, input logic [1:0] rs,
                                    input logic ill);
    return {pcw, irw, adr, mw, rw, imm, sa, sb, alu, rs, ill};
  endfunction

  function automatic logic [16:0] e_fetch(input logic mr);
    return v(mr, mr, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 3'b010, 2'b10, 1'b0);
  endfunction
  function automatic logic [16:0] e_dec(input logic is_jal);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, is_jal ? 2'b11 : 2'b10, 2'b01, 2'b01, 3'b010, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] e_madr(input logic is_sw);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, is_sw ? 2'b01 : 2'b00, 2'b10, 2'b01, 3'b010, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] e_mread();
    return v(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] e_memwb();
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0);
  endfunction
  function automatic logic [16:0] e_mwrite();
    return v(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] e_exec(input logic is_i, input logic [2:0] alu);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, is_i ? 2'b01 : 2'b00, alu, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] e_aluwb();
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] e_beq(input logic z);
    return v(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b011, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] e_jal();
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b010, 2'b00, 1'b0);
  endfunction
  function automatic logic [16:0] e_err();
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1);
  endfunction

  // One clock of stimulus: drive inputs after the edge and queue what both
  // instances must show during this cycle.
  task automatic cyc(input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic mr,
                     input logic [16:0] e, input logic nh_chk, input logic [16:0] enh,
                     input logic ret);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; op_code = op; funct3 = f3; funct7 = f7; zero = z; mem_ready = mr;
    x.e = e; x.cnt = cnt; x.nh = nh_chk; x.enh = enh;
    sbq.push_back(x);
    if (r) cnt = 0;
    else if (ret) cnt = cnt + 1;
  endtask

  task automatic c(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                   input logic z, input logic mr, input logic [16:0] e, input logic ret);
    cyc(1'b0, op, f3, f7, z, mr, e, 1'b1, e, ret);
  endtask

  task automatic do_reset();
    cyc(1'b1, 7'b0, 3'b0, 1'b0, 1'b0, 1'b1, 17'b0, 1'b1, 17'b0, 1'b0);
  endtask

  task automatic do_lw(input int waits);
    c(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b0);
    c(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, e_dec(1'b0), 1'b0);
    c(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, e_madr(1'b0), 1'b0);
    for (int i = 0; i < waits; i++)
      c(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, e_mread(), 1'b0);
    c(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, e_mread(), 1'b0);
    c(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, e_memwb(), 1'b1);
  endtask

  task automatic do_sw(input int fwaits, input int wwaits);
    for (int i = 0; i < fwaits; i++)
      c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), 1'b0);
    c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b0);
    c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_dec(1'b0), 1'b0);
    c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_madr(1'b1), 1'b0);
    for (int i = 0; i < wwaits; i++)
      c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, e_mwrite(), 1'b0);
    c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_mwrite(), 1'b1);
  endtask

  task automatic do_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [2:0] alu);
    c(op, f3, f7, 1'b0, 1'b1, e_fetch(1'b1), 1'b0);
    c(op, f3, f7, 1'b0, 1'b0, e_dec(1'b0), 1'b0);
    c(op, f3, f7, 1'b0, 1'b0, e_exec(op == OP_I, alu), 1'b0);
    c(op, f3, f7, 1'b0, 1'b0, e_aluwb(), 1'b1);
  endtask

  task automatic do_beq(input logic z);
    c(OP_BEQ, 3'b000, 1'b0, ~z, 1'b1, e_fetch(1'b1), 1'b0);
    c(OP_BEQ, 3'b000, 1'b0, ~z, 1'b1, e_dec(1'b0), 1'b0);
    c(OP_BEQ, 3'b000, 1'b0, z, 1'b1, e_beq(z), 1'b1);
  endtask

  task automatic do_jal();
    c(OP_JAL, 3'b101, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b0);
    c(OP_JAL, 3'b101, 1'b0, 1'b0, 1'b1, e_dec(1'b1), 1'b0);
    c(OP_JAL, 3'b101, 1'b0, 1'b0, 1'b1, e_jal(), 1'b0);
    c(OP_JAL, 3'b101, 1'b0, 1'b0, 1'b1, e_aluwb(), 1'b1);
  endtask

  // Halting instance parks in the error state; skipping instance is back in
  // fetch the cycle after decode with the counter unchanged.
  task automatic do_illegal(input logic [6:0] op, input logic [2:0] f3);
    c(op, f3, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b0);
    c(op, f3, 1'b0, 1'b0, 1'b1, e_dec(1'b0), 1'b0);
    cyc(1'b0, op, f3, 1'b0, 1'b0, 1'b1, e_err(), 1'b1, e_fetch(1'b1), 1'b0);
    cyc(1'b0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_err(), 1'b0, 17'b0, 1'b0);
    cyc(1'b0, OP_LW, 3'b010, 1'b0, 1'b1, 1'b0, e_err(), 1'b0, 17'b0, 1'b0);
    do_reset();
  endtask

  // Monitor: one expected entry per cycle, checked at the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        cyc_no++;
        checks++;
        if (act_main !== x.e) begin
          errors++;
          $display("FAIL ctrl cyc=%0d got=%b want=%b", cyc_no, act_main, x.e);
        end
        checks++;
        if (instret !== x.cnt) begin
          errors++;
          $display("FAIL instret cyc=%0d got=%0d want=%0d", cyc_no, instret, x.cnt);
        end
        if (x.nh) begin
          checks++;
          if (act_nh !== x.enh) begin
            errors++;
            $display("FAIL nh_ctrl cyc=%0d got=%b want=%b", cyc_no, act_nh, x.enh);
          end
          checks++;
          if (n_instret !== x.cnt) begin
            errors++;
            $display("FAIL nh_instret cyc=%0d got=%0d want=%0d", cyc_no, n_instret, x.cnt);
          end
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    do_reset();
    do_reset();
    do_lw(0);
    do_lw(3);
    do_sw(1, 1);
    do_alu(OP_R, 3'b000, 1'b1, 3'b011);
    do_alu(OP_R, 3'b000, 1'b0, 3'b010);
    do_alu(OP_I, 3'b000, 1'b1, 3'b010);
    do_alu(OP_R, 3'b010, 1'b0, 3'b110);
    do_alu(OP_I, 3'b110, 1'b0, 3'b100);
    do_alu(OP_R, 3'b111, 1'b0, 3'b101);
    do_beq(1'b1);
    do_beq(1'b0);
    do_jal();
    do_illegal(OP_LW, 3'b000);
    do_illegal(7'b1111111, 3'b000);
    // Abort a store mid-write: reset must kill mem_write immediately.
    c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_fetch(1'b1), 1'b0);
    c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_dec(1'b0), 1'b0);
    c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, e_madr(1'b1), 1'b0);
    c(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, e_mwrite(), 1'b0);
    cyc(1'b1, OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 17'b0, 1'b1, 17'b0, 1'b0);
    do_beq(1'b1);
    @(posedge clk);
    @(posedge clk);
    stim_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    while (!stim_done && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    checks++;
    if (!stim_done || sbq.size() != 0) begin
      errors++;
      $display("FAIL drain done=%0d pending=%0d want done=1 pending=0", stim_done, sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
